// File: rtl/scr1_timer_cmp.sv
`default_nettype none
// ============================================================================
// Module   : scr1_timer_cmp
// Purpose  : Multi-channel mtime compare unit with periodic reload and IRQs.
// Revision : 1.0
// ============================================================================

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

module scr1_timer_cmp #(
  parameter int NUM_CH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [63:0]                  timer_val,
  input  logic                         dmem_req,
  input  logic                         dmem_cmd,
  input  logic [1:0]                   dmem_width,
  input  logic [`SCR1_DMEM_AWIDTH-1:0] dmem_addr,
  input  logic [`SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
  output logic                         dmem_req_ack,
  output logic [`SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
  output logic [1:0]                   dmem_resp,
  output logic [NUM_CH-1:0]            cmp_irq
);

  localparam logic [1:0] WIDTH_WORD  = 2'd2;
  localparam logic [1:0] RESP_NOTRDY = 2'd0;
  localparam logic [1:0] RESP_RDY_OK = 2'd1;
  localparam logic [1:0] RESP_RDY_ER = 2'd2;
  localparam logic [6:0] ADDR_PEND   = 7'h40;
  localparam logic [6:0] ADDR_IEN    = 7'h44;
  localparam logic [2:0] NUM_CH_W    = 3'(NUM_CH);

  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_CMPLO   = 2'd1;
  localparam logic [1:0] OFF_CMPHI   = 2'd2;
  localparam logic [1:0] OFF_PERIOD  = 2'd3;

  // Address decode
  logic [6:0] reg_addr;
  logic [1:0] ch_sel;
  logic [1:0] reg_off;
  logic       ch_space;
  logic       ch_exists;
  logic       sel_pend;
  logic       sel_ien;
  logic       req_valid;
  logic       wr_en;
  logic       unused_addr;

  assign reg_addr    = dmem_addr[6:0];
  assign ch_sel      = reg_addr[5:4];
  assign reg_off     = reg_addr[3:2];
  assign ch_space    = ~reg_addr[6];
  assign ch_exists   = ({1'b0, ch_sel} < NUM_CH_W);
  assign sel_pend    = (reg_addr == ADDR_PEND);
  assign sel_ien     = (reg_addr == ADDR_IEN);
  assign req_valid   = (dmem_width == WIDTH_WORD) & (reg_addr[1:0] == 2'b00) &
                       ((ch_space & ch_exists) | sel_pend | sel_ien);
  assign wr_en       = dmem_req & req_valid & dmem_cmd;
  assign unused_addr = ^dmem_addr[`SCR1_DMEM_AWIDTH-1:7];

  // Channel state, gathered for the read mux and shared registers
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] ch_periodic;
  logic [NUM_CH-1:0] match;
  logic [63:0]       ch_cmp    [NUM_CH];
  logic [31:0]       ch_period [NUM_CH];

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] ien;
  logic [NUM_CH-1:0] irq;
  logic [NUM_CH-1:0] pend_clr;
  logic              wr_pend;
  logic              wr_ien;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    localparam logic [1:0] CH_IDX = 2'(n);

    logic        en_q;
    logic        per_q;
    logic [63:0] cmp_q;
    logic [31:0] period_q;
    logic [63:0] reload;
    logic        hit;
    logic        wr_ctrl;
    logic        wr_lo;
    logic        wr_hi;
    logic        wr_period;

    assign hit       = wr_en & ch_space & (ch_sel == CH_IDX);
    assign wr_ctrl   = hit & (reg_off == OFF_CTRL);
    assign wr_lo     = hit & (reg_off == OFF_CMPLO);
    assign wr_hi     = hit & (reg_off == OFF_CMPHI);
    assign wr_period = hit & (reg_off == OFF_PERIOD);
    assign reload    = cmp_q + {32'b0, period_q};

    assign match[n]       = en_q & (timer_val >= cmp_q);
    assign ch_en[n]       = en_q;
    assign ch_periodic[n] = per_q;
    assign ch_cmp[n]      = cmp_q;
    assign ch_period[n]   = period_q;

    // Software writes take priority over the hardware reload / one-shot disable
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        en_q     <= 1'b0;
        per_q    <= 1'b0;
        cmp_q    <= 64'd0;
        period_q <= 32'd0;
      end else begin
        if (wr_ctrl) begin
          en_q  <= dmem_wdata[0];
          per_q <= dmem_wdata[1];
        end else if (match[n] & ~per_q) begin
          en_q  <= 1'b0;
        end

        if (wr_lo | wr_hi) begin
          if (wr_lo) cmp_q[31:0]  <= dmem_wdata[31:0];
          if (wr_hi) cmp_q[63:32] <= dmem_wdata[31:0];
        end else if (match[n] & per_q) begin
          cmp_q <= reload;
        end

        if (wr_period) period_q <= dmem_wdata[31:0];
      end
    end
  end

  assign wr_pend  = wr_en & sel_pend;
  assign wr_ien   = wr_en & sel_ien;
  assign pend_clr = wr_pend ? dmem_wdata[NUM_CH-1:0] : '0;

  // A match in the same cycle as a write-1-to-clear leaves the bit set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      ien  <= '0;
      irq  <= '0;
    end else begin
      pend <= (pend & ~pend_clr) | match;
      if (wr_ien) ien <= dmem_wdata[NUM_CH-1:0];
      irq  <= pend & ien;
    end
  end

  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = 32'd0;
    if (sel_pend) begin
      rd_mux[NUM_CH-1:0] = pend;
    end else if (sel_ien) begin
      rd_mux[NUM_CH-1:0] = ien;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_sel == 2'(i)) begin
          case (reg_off)
            OFF_CTRL:   rd_mux = {30'd0, ch_periodic[i], ch_en[i]};
            OFF_CMPLO:  rd_mux = ch_cmp[i][31:0];
            OFF_CMPHI:  rd_mux = ch_cmp[i][63:32];
            default:    rd_mux = ch_period[i];
          endcase
        end
      end
    end
  end

  // Error responses keep the last read data on the bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_resp  <= RESP_NOTRDY;
      dmem_rdata <= '0;
    end else if (dmem_req) begin
      if (req_valid) begin
        dmem_resp  <= RESP_RDY_OK;
        dmem_rdata <= `SCR1_DMEM_DWIDTH'(rd_mux);
      end else begin
        dmem_resp  <= RESP_RDY_ER;
      end
    end else begin
      dmem_resp  <= RESP_NOTRDY;
      dmem_rdata <= '0;
    end
  end

  assign dmem_req_ack = 1'b1;
  assign cmp_irq      = irq;

endmodule

`default_nettype wire

// File: tb/tb_scr1_timer_cmp.sv
`default_nettype none
// ============================================================================
// Module   : tb_scr1_timer_cmp
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic.
// Revision : 1.0
// ============================================================================

module tb_scr1_timer_cmp;

  localparam int NCH = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] timer_val;
  logic        dmem_req;
  logic        dmem_cmd;
  logic [1:0]  dmem_width;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_req_ack;
  logic [31:0] dmem_rdata;
  logic [1:0]  dmem_resp;
  logic [NCH-1:0] cmp_irq;

  int checks = 0;
  int errors = 0;

  scr1_timer_cmp #(.NUM_CH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .timer_val(timer_val),
    .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_req_ack(dmem_req_ack), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .cmp_irq(cmp_irq)
  );

  always #5 clk = ~clk;

  // Reference model: architectural register contents
  logic [NCH-1:0] m_en, m_per, m_pend, m_ien, m_irq;
  logic [63:0]    m_cmp    [NCH];
  logic [31:0]    m_period [NCH];
  logic [1:0]     m_resp;
  logic [31:0]    m_rdata;

  task automatic model_reset();
    m_en = '0; m_per = '0; m_pend = '0; m_ien = '0; m_irq = '0;
    m_resp = 2'd0; m_rdata = 32'd0;
    for (int c = 0; c < NCH; c++) begin
      m_cmp[c] = 64'd0;
      m_period[c] = 32'd0;
    end
  endtask

  function automatic bit mdl_valid(input logic [1:0] w, input logic [6:0] a);
    if (w != 2'd2 || a[1:0] != 2'b00) return 1'b0;
    if (a == 7'h40 || a == 7'h44) return 1'b1;
    return (a < 7'h40) && (int'(a[5:4]) < NCH);
  endfunction

  function automatic logic [31:0] mdl_read(input logic [6:0] a);
    int c;
    if (a == 7'h40) return 32'(m_pend);
    if (a == 7'h44) return 32'(m_ien);
    c = int'(a[5:4]);
    case (a[3:2])
      2'd0:    return {30'd0, m_per[c], m_en[c]};
      2'd1:    return m_cmp[c][31:0];
      2'd2:    return m_cmp[c][63:32];
      default: return m_period[c];
    endcase
  endfunction

  // Drive one bus cycle, advance the model across the clock edge
  task automatic tick(input bit req, input bit cmd, input logic [1:0] w,
                      input logic [6:0] a, input logic [31:0] d, input logic [63:0] t);
    bit ok, wr, hit, wch, cmpw;
    logic [NCH-1:0] n_en, n_per, n_pend, n_ien, n_irq;
    logic [63:0] n_cmp [NCH];
    logic [31:0] n_period [NCH];
    logic [1:0]  n_resp;
    logic [31:0] n_rdata;
    dmem_req = req; dmem_cmd = cmd; dmem_width = w;
    dmem_addr = {25'd0, a}; dmem_wdata = d; timer_val = t;
    ok = mdl_valid(w, a);
    wr = req && ok && cmd;
    n_irq = m_pend & m_ien;
    n_resp = !req ? 2'd0 : (ok ? 2'd1 : 2'd2);
    n_rdata = !req ? 32'd0 : (ok ? mdl_read(a) : m_rdata);
    n_pend = m_pend; n_ien = m_ien; n_en = m_en; n_per = m_per;
    if (wr && a == 7'h40) n_pend = n_pend & ~d[NCH-1:0];
    if (wr && a == 7'h44) n_ien = d[NCH-1:0];
    for (int c = 0; c < NCH; c++) begin
      n_cmp[c] = m_cmp[c];
      n_period[c] = m_period[c];
      hit  = m_en[c] && (t >= m_cmp[c]);
      wch  = wr && (a < 7'h40) && (int'(a[5:4]) == c);
      cmpw = wch && (a[3:2] == 2'd1 || a[3:2] == 2'd2);
      if (hit) begin
        n_pend[c] = 1'b1;
        if (m_per[c]) begin
          if (!cmpw) n_cmp[c] = m_cmp[c] + {32'd0, m_period[c]};
        end else begin
          n_en[c] = 1'b0;
        end
      end
      if (wch) begin
        case (a[3:2])
          2'd0: begin n_en[c] = d[0]; n_per[c] = d[1]; end
          2'd1: n_cmp[c][31:0] = d;
          2'd2: n_cmp[c][63:32] = d;
          default: n_period[c] = d;
        endcase
      end
    end
    @(posedge clk);
    m_en = n_en; m_per = n_per; m_pend = n_pend; m_ien = n_ien; m_irq = n_irq;
    m_resp = n_resp; m_rdata = n_rdata;
    for (int c = 0; c < NCH; c++) begin
      m_cmp[c] = n_cmp[c];
      m_period[c] = n_period[c];
    end
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [63:0] t);
    tick(1'b1, 1'b1, 2'd2, a, d, t);
  endtask

  task automatic rd(input logic [6:0] a, input logic [63:0] t);
    tick(1'b1, 1'b0, 2'd2, a, 32'd0, t);
  endtask

  task automatic idle(input logic [63:0] t);
    tick(1'b0, 1'b0, 2'd2, 7'h00, 32'd0, t);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dmem_req = 1'b0; dmem_cmd = 1'b0; dmem_width = 2'd2;
    dmem_addr = 32'd0; dmem_wdata = 32'd0; timer_val = 64'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dmem_resp !== 2'd0) begin errors++; $display("FAIL reset_resp: got %0d want 0", dmem_resp); end
    checks++; if (dmem_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", dmem_rdata); end
    checks++; if (cmp_irq !== 3'd0) begin errors++; $display("FAIL reset_irq: got %b want 000", cmp_irq); end
    checks++; if (dmem_req_ack !== 1'b1) begin errors++; $display("FAIL req_ack: got %b want 1", dmem_req_ack); end
    @(negedge clk);
    rst_n = 1'b1;
    rd(7'h00, 64'd0);
    checks++; if (dmem_resp !== 2'd1 || dmem_rdata !== 32'd0) begin
      errors++; $display("FAIL reset_ctrl0: got resp %0d data %h want 1/0", dmem_resp, dmem_rdata); end
  endtask

  task automatic test_oneshot();
    wr(7'h04, 32'd100, 64'd0); wr(7'h08, 32'd0, 64'd0);
    wr(7'h44, 32'd1, 64'd0);   wr(7'h00, 32'd1, 64'd0);
    idle(64'd98); idle(64'd99);
    checks++; if (cmp_irq !== 3'd0) begin errors++; $display("FAIL oneshot_early: got %b want 000", cmp_irq); end
    idle(64'd100);
    checks++; if (cmp_irq !== 3'd0) begin errors++; $display("FAIL oneshot_irq_lat: got %b want 000", cmp_irq); end
    idle(64'd101);
    checks++; if (cmp_irq !== 3'b001) begin errors++; $display("FAIL oneshot_irq: got %b want 001", cmp_irq); end
    rd(7'h40, 64'd101);
    checks++; if (dmem_rdata !== 32'd1) begin errors++; $display("FAIL oneshot_pend: got %h want 1", dmem_rdata); end
    rd(7'h00, 64'd101);
    checks++; if (dmem_rdata !== 32'd0) begin errors++; $display("FAIL oneshot_en_clr: got %h want 0", dmem_rdata); end
    wr(7'h40, 32'd1, 64'd0); idle(64'd0);
    checks++; if (cmp_irq !== 3'd0) begin errors++; $display("FAIL oneshot_irq_clr: got %b want 000", cmp_irq); end
  endtask

  task automatic test_periodic();
    wr(7'h14, 32'd50, 64'd0); wr(7'h18, 32'd0, 64'd0); wr(7'h1C, 32'd10, 64'd0);
    wr(7'h44, 32'd2, 64'd0);  wr(7'h10, 32'd3, 64'd0);
    idle(64'd50);
    rd(7'h14, 64'd50);
    checks++; if (dmem_rdata !== 32'd60) begin errors++; $display("FAIL periodic_reload: got %0d want 60", dmem_rdata); end
    rd(7'h40, 64'd50);
    checks++; if (dmem_rdata !== 32'd2) begin errors++; $display("FAIL periodic_pend: got %h want 2", dmem_rdata); end
    checks++; if (cmp_irq !== 3'b010) begin errors++; $display("FAIL periodic_irq: got %b want 010", cmp_irq); end
    wr(7'h40, 32'd2, 64'd50);
    checks++; if (cmp_irq !== 3'b010) begin errors++; $display("FAIL periodic_irq_hold: got %b want 010", cmp_irq); end
    idle(64'd50);
    checks++; if (cmp_irq !== 3'b000) begin errors++; $display("FAIL periodic_irq_drop: got %b want 000", cmp_irq); end
    rd(7'h40, 64'd50);
    checks++; if (dmem_rdata !== 32'd0) begin errors++; $display("FAIL periodic_w1c: got %h want 0", dmem_rdata); end
    wr(7'h10, 32'd0, 64'd0);
  endtask

  task automatic test_wrap();
    wr(7'h24, 32'hFFFF_FFFC, 64'd0); wr(7'h28, 32'hFFFF_FFFF, 64'd0);
    wr(7'h2C, 32'd8, 64'd0);         wr(7'h20, 32'd3, 64'd0);
    idle(64'hFFFF_FFFF_FFFF_FFFF);
    rd(7'h24, 64'd0);
    checks++; if (dmem_rdata !== 32'd4) begin errors++; $display("FAIL wrap_lo: got %h want 4", dmem_rdata); end
    rd(7'h28, 64'd0);
    checks++; if (dmem_rdata !== 32'd0) begin errors++; $display("FAIL wrap_hi: got %h want 0", dmem_rdata); end
    wr(7'h20, 32'd0, 64'd0); wr(7'h40, 32'd4, 64'd0);
  endtask

  task automatic test_collision();
    wr(7'h04, 32'd200, 64'd0); wr(7'h08, 32'd0, 64'd0); wr(7'h00, 32'd1, 64'd0);
    wr(7'h40, 32'd1, 64'd300);
    rd(7'h40, 64'd0);
    checks++; if (dmem_rdata[0] !== 1'b1) begin errors++; $display("FAIL coll_w1c: got %h want bit0=1", dmem_rdata); end
    rd(7'h00, 64'd0);
    checks++; if (dmem_rdata !== 32'd0) begin errors++; $display("FAIL coll_oneshot: got %h want 0", dmem_rdata); end
    wr(7'h0C, 32'h1000, 64'd0); wr(7'h04, 32'd200, 64'd0); wr(7'h00, 32'd3, 64'd0);
    wr(7'h04, 32'h200, 64'd300);
    rd(7'h04, 64'd0);
    checks++; if (dmem_rdata !== 32'h200) begin errors++; $display("FAIL coll_cmplo: got %h want 200", dmem_rdata); end
    rd(7'h08, 64'd0);
    checks++; if (dmem_rdata !== 32'd0) begin errors++; $display("FAIL coll_cmphi: got %h want 0", dmem_rdata); end
    wr(7'h40, 32'd1, 64'd0);
    wr(7'h00, 32'd2, 64'h300);
    rd(7'h00, 64'd0);
    checks++; if (dmem_rdata !== 32'd2) begin errors++; $display("FAIL coll_ctrl: got %h want 2", dmem_rdata); end
    rd(7'h40, 64'd0);
    checks++; if (dmem_rdata[0] !== 1'b1) begin errors++; $display("FAIL coll_ctrl_pend: got %h want bit0=1", dmem_rdata); end
    wr(7'h40, 32'd7, 64'd0);
  endtask

  task automatic test_errors();
    logic [6:0] bad [4] = '{7'h42, 7'h48, 7'h30, 7'h06};
    wr(7'h04, 32'h1234, 64'd0);
    rd(7'h04, 64'd0);
    checks++; if (dmem_rdata !== 32'h1234) begin errors++; $display("FAIL err_setup: got %h want 1234", dmem_rdata); end
    tick(1'b1, 1'b0, 2'd1, 7'h04, 32'd0, 64'd0);
    checks++; if (dmem_resp !== 2'd2 || dmem_rdata !== 32'h1234) begin
      errors++; $display("FAIL err_hword: got resp %0d data %h want 2/1234", dmem_resp, dmem_rdata); end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, i[0], 2'd2, bad[i], 32'hDEAD_BEEF, 64'd0);
      checks++; if (dmem_resp !== 2'd2 || dmem_rdata !== 32'h1234) begin
        errors++; $display("FAIL err_addr_%h: got resp %0d data %h want 2/1234", bad[i], dmem_resp, dmem_rdata); end
    end
    tick(1'b1, 1'b1, 2'd0, 7'h04, 32'hDEAD, 64'd0);
    rd(7'h04, 64'd0);
    checks++; if (dmem_rdata !== 32'h1234) begin errors++; $display("FAIL err_nochange: got %h want 1234", dmem_rdata); end
    rd(7'h44, 64'd0);
    checks++; if (dmem_rdata !== 32'd2) begin errors++; $display("FAIL err_ien: got %h want 2", dmem_rdata); end
    idle(64'd0);
    checks++; if (dmem_resp !== 2'd0 || dmem_rdata !== 32'd0) begin
      errors++; $display("FAIL err_idle: got resp %0d data %h want 0/0", dmem_resp, dmem_rdata); end
  endtask

  task automatic test_random();
    logic [6:0] addrs [17] = '{7'h00, 7'h04, 7'h08, 7'h0C, 7'h10, 7'h14, 7'h18, 7'h1C,
                               7'h20, 7'h24, 7'h28, 7'h2C, 7'h40, 7'h44, 7'h30, 7'h42, 7'h7C};
    logic [6:0]  a;
    logic [31:0] d;
    logic [1:0]  w;
    bit          req, cmd;
    for (int it = 0; it < 400; it++) begin
      a   = addrs[$urandom_range(0, 16)];
      req = ($urandom_range(0, 9) < 8);
      cmd = $urandom_range(0, 1);
      w   = ($urandom_range(0, 9) == 0) ? 2'd1 : 2'd2;
      case (a[3:2])
        2'd0:    d = (a == 7'h40 || a == 7'h44) ? $urandom : $urandom_range(0, 3);
        2'd1:    d = $urandom_range(0, 500);
        2'd2:    d = ($urandom_range(0, 7) == 0) ? 32'd1 : 32'd0;
        default: d = $urandom_range(0, 30);
      endcase
      tick(req, cmd, w, a, d, 64'($urandom_range(0, 600)));
      checks++; if (dmem_resp !== m_resp) begin errors++; $display("FAIL rand_resp[%0d]: got %0d want %0d", it, dmem_resp, m_resp); end
      checks++; if (dmem_rdata !== m_rdata) begin errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", it, dmem_rdata, m_rdata); end
      checks++; if (cmp_irq !== m_irq) begin errors++; $display("FAIL rand_irq[%0d]: got %b want %b", it, cmp_irq, m_irq); end
    end
  endtask

  task automatic test_reset_mid();
    wr(7'h10, 32'd0, 64'd0); wr(7'h40, 32'd7, 64'd0);
    wr(7'h14, 32'd10, 64'd0); wr(7'h18, 32'd0, 64'd0); wr(7'h1C, 32'd5, 64'd0);
    wr(7'h44, 32'd2, 64'd0);  wr(7'h10, 32'd3, 64'd0);
    idle(64'd20); idle(64'd25);
    checks++; if (cmp_irq[1] !== 1'b1) begin errors++; $display("FAIL rstmid_pre_irq: got %b want x1x", cmp_irq); end
    dmem_req = 1'b1; dmem_cmd = 1'b1; dmem_width = 2'd2; dmem_addr = 32'h14; dmem_wdata = 32'h999;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cmp_irq !== 3'd0) begin errors++; $display("FAIL rstmid_irq: got %b want 000", cmp_irq); end
    checks++; if (dmem_resp !== 2'd0 || dmem_rdata !== 32'd0) begin
      errors++; $display("FAIL rstmid_resp: got resp %0d data %h want 0/0", dmem_resp, dmem_rdata); end
    dmem_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(64'd1000); idle(64'd1000);
    checks++; if (cmp_irq !== 3'd0) begin errors++; $display("FAIL rstmid_post_irq: got %b want 000", cmp_irq); end
    rd(7'h40, 64'd1000);
    checks++; if (dmem_rdata !== 32'd0) begin errors++; $display("FAIL rstmid_pend: got %h want 0", dmem_rdata); end
    rd(7'h14, 64'd1000);
    checks++; if (dmem_rdata !== 32'd0) begin errors++; $display("FAIL rstmid_cmplo: got %h want 0", dmem_rdata); end
    rd(7'h10, 64'd1000);
    checks++; if (dmem_rdata !== 32'd0) begin errors++; $display("FAIL rstmid_ctrl: got %h want 0", dmem_rdata); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_wrap();
    test_collision();
    test_errors();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scr1_timer_cmp.md
SCR1_TIMER_CMP -- requirements
Module: scr1_timer_cmp

Interface
REQ-001 Parameter NUM_CH, default 4, meaning number of compare channels (1..4).
REQ-002 clk  input  1  core clock; the only clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 timer_val  input  64  mtime value from the memory-mapped timer.
REQ-005 dmem_req  input  1  register access request.
REQ-006 dmem_cmd  input  1  0=RD, 1=WR.
REQ-007 dmem_width  input  2  type_scr1_mem_width_e; only WORD is legal.
REQ-008 dmem_addr  input  `SCR1_DMEM_AWIDTH  byte address; bits [6:0] decoded.
REQ-009 dmem_wdata  input  `SCR1_DMEM_DWIDTH  write data.
REQ-010 dmem_req_ack  output  1  constant 1.
REQ-011 dmem_rdata  output  `SCR1_DMEM_DWIDTH  registered read data.
REQ-012 dmem_resp  output  2  registered: NOTRDY / RDY_OK / RDY_ER.
REQ-013 cmp_irq  output  NUM_CH  per-channel registered interrupt.

Function
REQ-014 Per channel n (base n*0x10) SHALL provide: CTRL +0x0 (bit0 EN, bit1 PERIODIC), CMPLO +0x4, CMPHI +0x8, PERIOD +0xC (32-bit).
REQ-015 0x40 PEND (bit n per channel, read / write-1-to-clear) and 0x44 IEN (bit n, read/write) SHALL be provided; unused upper bits read 0, writes ignored.
REQ-016 Request valid SHALL require width WORD, addr[1:0]==0, and addr[6:0] mapping to an implemented register (channel index < NUM_CH or 0x40/0x44).
REQ-017 Cycle with dmem_req: next cycle dmem_resp=RDY_OK if valid, else RDY_ER with no register change; cycle without dmem_req: next cycle dmem_resp=NOTRDY, dmem_rdata=0.
REQ-018 Read data SHALL be captured on the request-cycle edge from pre-write register values; on RDY_ER, dmem_rdata holds its previous value.
REQ-019 Writes SHALL take effect on the edge closing the request cycle.
REQ-020 Match_n SHALL be EN_n & (timer_val >= CMP_n), unsigned 64-bit compare using registered CMP_n, evaluated every cycle.
REQ-021 On match_n: PEND_n<=1; if PERIODIC_n, CMP_n<=CMP_n+{32'b0,PERIOD_n} modulo 2^64 (wraps silently); else EN_n<=0 (one-shot).
REQ-022 Same-cycle match and software write to CMPLO/CMPHI of that channel: software write wins for written half; reload SHALL NOT update either half; PEND still set.
REQ-023 Same-cycle match and CTRL write: CTRL write value wins for EN/PERIODIC; PEND still set.
REQ-024 Same-cycle W1C of PEND_n and match_n: PEND_n SHALL end at 1 (set wins).
REQ-025 PERIOD=0 in periodic mode: CMP unchanged, match and PEND re-asserted every cycle while timer_val >= CMP.
REQ-026 cmp_irq[n] SHALL be registered PEND_n & IEN_n, one cycle after the source registers update.
REQ-027 Channel with EN=0 SHALL never set PEND; existing PEND persists until cleared.

Reset
REQ-028 On rst_n low, asynchronously: all CTRL, CMP, PERIOD, PEND, IEN = 0; cmp_irq=0; dmem_resp=NOTRDY; dmem_rdata=0.
REQ-029 Reset asserted mid-access SHALL abort the response; no partial register update survives.

Verification
REQ-030 Ch0 CMP=100, IEN0=1, CTRL=0x1, timer_val ramps 98->101 -> PEND0 set on edge after timer_val=100, cmp_irq[0] one cycle later, EN0 reads 0.
REQ-031 Ch1 CMP=50, PERIOD=10, CTRL=0x3, timer_val held 50 -> CMP1 reads 60 next cycle, PEND1=1; write PEND=0x2 -> PEND1=0, cmp_irq[1] drops one cycle later.
REQ-032 Ch2 CMP=0xFFFFFFFF_FFFFFFFC, PERIOD=8, periodic, timer_val=0xFFFFFFFF_FFFFFFFF -> CMP2 wraps to 0x4.
REQ-033 Same cycle: match_0 and W1C PEND=0x1 -> PEND0 stays 1; match_0 and CMPLO0 write 0x200 -> CMPLO0=0x200, CMPHI0 unchanged.
REQ-034 Half-word read, addr 0x42, addr 0x48, addr 0x30 with NUM_CH=2 -> RDY_ER each, no register changes; idle cycle -> NOTRDY, rdata 0.
REQ-035 rst_n pulsed low during pending irq and periodic run -> all registers 0, cmp_irq=0 immediately, no match after release until reprogrammed.
